// File: rtl/cpu_step_controller.sv
// cpu_step_controller: run-control for the ARMv4 core (reset sequencing, clock-enable gating, stepping, cycle count)
// Ports:
//   clk, rst              system clock (rising edge), asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; accepted on an edge where both are high
//   cmd_op, cmd_count     00 HALT, 01 STEP (cmd_count cycles), 10 RUN, 11 RESET_CORE
//   core_en, core_rst     clock enable and active-high reset driven to the processor
//   busy, done            stepping/running; one-cycle pulse when a step finishes or is halted
//   cmd_err               sticky: STEP/RUN offered while busy
//   remaining             steps left including the current cycle
//   cycle_count           saturating count of cycles with core_en high
module cpu_step_controller #(
    parameter int CNT_W    = 16,
    parameter int CYC_W    = 32,
    parameter int RST_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             core_en,
    output logic             core_rst,
    output logic             busy,
    output logic             done,
    output logic             cmd_err,
    output logic [CNT_W-1:0] remaining,
    output logic [CYC_W-1:0] cycle_count
);
    localparam int HW = RST_HOLD > 0 ? $clog2(RST_HOLD + 1) : 1;
    localparam logic [1:0] OP_HALT  = 2'b00;
    localparam logic [1:0] OP_STEP  = 2'b01;
    localparam logic [1:0] OP_RUN   = 2'b10;
    localparam logic [1:0] OP_RESET = 2'b11;

    typedef enum logic [1:0] {RST_HOLD_S, HALT_S, STEP_S, RUN_S} state_t;

    state_t           state;
    logic [HW-1:0]    hold;
    logic             accept;
    logic [CYC_W-1:0] cyc_inc;

    assign cmd_ready = state != RST_HOLD_S;
    // core_en is high exactly while in STEP_S or RUN_S
    assign busy      = core_en;
    assign accept    = cmd_valid & cmd_ready;
    assign cyc_inc   = &cycle_count ? cycle_count : cycle_count + CYC_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RST_HOLD_S;
            hold        <= HW'(RST_HOLD);
            core_rst    <= 1'b1;
            core_en     <= 1'b0;
            done        <= 1'b0;
            cmd_err     <= 1'b0;
            remaining   <= '0;
            cycle_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                RST_HOLD_S: begin
                    if (hold == '0) begin
                        core_rst <= 1'b0;
                        state    <= HALT_S;
                    end else begin
                        hold <= hold - HW'(1);
                    end
                end
                HALT_S: begin
                    if (accept) begin
                        case (cmd_op)
                            OP_STEP: begin
                                if (cmd_count != '0) begin
                                    core_en   <= 1'b1;
                                    remaining <= cmd_count;
                                    state     <= STEP_S;
                                end else begin
                                    done <= 1'b1;
                                end
                            end
                            OP_RUN: begin
                                core_en <= 1'b1;
                                state   <= RUN_S;
                            end
                            OP_RESET: begin
                                core_rst    <= 1'b1;
                                hold        <= HW'(RST_HOLD);
                                cycle_count <= '0;
                                state       <= RST_HOLD_S;
                            end
                            default: ;
                        endcase
                    end
                end
                default: begin
                    // every edge spent in STEP_S/RUN_S is an enabled cycle, including a HALT edge
                    cycle_count <= cyc_inc;
                    if (accept && cmd_op == OP_HALT) begin
                        core_en   <= 1'b0;
                        remaining <= '0;
                        done      <= 1'b1;
                        state     <= HALT_S;
                    end else if (accept && cmd_op == OP_RESET) begin
                        core_en     <= 1'b0;
                        remaining   <= '0;
                        core_rst    <= 1'b1;
                        hold        <= HW'(RST_HOLD);
                        cycle_count <= '0;
                        state       <= RST_HOLD_S;
                    end else begin
                        if (accept) cmd_err <= 1'b1;
                        if (state == STEP_S) begin
                            remaining <= remaining - CNT_W'(1);
                            if (remaining == CNT_W'(1)) begin
                                core_en <= 1'b0;
                                done    <= 1'b1;
                                state   <= HALT_S;
                            end
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_step_controller.sv
// tb_cpu_step_controller: directed bench for cpu_step_controller with a cycle-level expectation model
module tb_cpu_step_controller;
    localparam int HOLD = 4;

    logic        clk = 1'b0, rst = 1'b0, cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'b00;
    logic [15:0] cmd_count = '0;

    logic        cmd_ready, core_en, core_rst, busy, done, cmd_err;
    logic [15:0] remaining;
    logic [31:0] cycle_count;
    logic        s4_ready, s4_en, s4_rst, s4_busy, s4_done, s4_err;
    logic [15:0] s4_rem;
    logic [3:0]  s4_cc;
    logic        z_ready, z_en, z_rst, z_busy, z_done, z_err;
    logic [15:0] z_rem;
    logic [31:0] z_cc;

    cpu_step_controller #(.CNT_W(16), .CYC_W(32), .RST_HOLD(HOLD)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_count(cmd_count), .core_en(core_en), .core_rst(core_rst), .busy(busy), .done(done),
        .cmd_err(cmd_err), .remaining(remaining), .cycle_count(cycle_count));

    cpu_step_controller #(.CNT_W(16), .CYC_W(4), .RST_HOLD(HOLD)) dut4 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(s4_ready), .cmd_op(cmd_op),
        .cmd_count(cmd_count), .core_en(s4_en), .core_rst(s4_rst), .busy(s4_busy), .done(s4_done),
        .cmd_err(s4_err), .remaining(s4_rem), .cycle_count(s4_cc));

    cpu_step_controller #(.CNT_W(16), .CYC_W(32), .RST_HOLD(0)) dut0 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(z_ready), .cmd_op(cmd_op),
        .cmd_count(cmd_count), .core_en(z_en), .core_rst(z_rst), .busy(z_busy), .done(z_done),
        .cmd_err(z_err), .remaining(z_rem), .cycle_count(z_cc));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: in_rst/hold_left = core reset window, en_left = enabled cycles still owed
    // (-1 = free run), cycles = unsaturated count of enabled cycles.
    bit     in_rst = 1'b1, err = 1'b0, m_done = 1'b0;
    int     hold_left = HOLD;
    longint en_left = 0, cycles = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            in_rst <= 1'b1; hold_left <= HOLD; en_left <= 0; cycles <= 0; err <= 1'b0; m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (en_left != 0) cycles <= cycles + 1;
            if (in_rst) begin
                if (hold_left == 0) in_rst <= 1'b0;
                else hold_left <= hold_left - 1;
            end else if (cmd_valid && cmd_op == 2'b11) begin
                en_left <= 0; in_rst <= 1'b1; hold_left <= HOLD; cycles <= 0;
            end else if (en_left != 0) begin
                if (cmd_valid && cmd_op == 2'b00) begin
                    en_left <= 0; m_done <= 1'b1;
                end else begin
                    if (cmd_valid) err <= 1'b1;
                    if (en_left > 0) en_left <= en_left - 1;
                    if (en_left == 1) m_done <= 1'b1;
                end
            end else if (cmd_valid) begin
                if (cmd_op == 2'b01) begin
                    if (cmd_count == 0) m_done <= 1'b1;
                    else en_left <= cmd_count;
                end else if (cmd_op == 2'b10) begin
                    en_left <= -1;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("m_ready", cmd_ready, !in_rst);
        chk("m_core_rst", core_rst, in_rst);
        chk("m_core_en", core_en, en_left != 0);
        chk("m_busy", busy, en_left != 0);
        chk("m_done", done, m_done);
        chk("m_cmd_err", cmd_err, err);
        chk("m_remaining", remaining, en_left > 0 ? en_left : 0);
        chk("m_cycle_count", cycle_count, cycles);
        chk("m_cycle_count_w4", s4_cc, cycles > 15 ? 15 : cycles);
    end

    task automatic cmd(input logic [1:0] op, input logic [15:0] n);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_count = n;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_core_rst", core_rst, 1);
        chk("rst_core_en", core_en, 0);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_cycle_count", cycle_count, 0);
        chk("rst_cmd_err", cmd_err, 0);
        chk("rst_hold0_core_rst", z_rst, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("hold0_core_rst", z_rst, 0);
        chk("hold0_ready", z_ready, 1);
        chk("hold_e1_core_rst", core_rst, 1);
        chk("hold_e1_ready", cmd_ready, 0);
        repeat (3) begin
            @(negedge clk);
            chk("hold_core_rst", core_rst, 1);
            chk("hold_ready", cmd_ready, 0);
        end
        @(negedge clk);
        chk("hold_end_core_rst", core_rst, 0);
        chk("hold_end_ready", cmd_ready, 1);
        chk("hold_end_core_en", core_en, 0);
    endtask

    initial begin
        #1 rst = 1'b1;
        do_reset();

        cmd(2'b00, 0);
        chk("idle_halt_en", core_en, 0);
        chk("idle_halt_done", done, 0);

        cmd(2'b01, 3);
        chk("step3_rem3", remaining, 3);
        chk("step3_en", core_en, 1);
        @(negedge clk); chk("step3_rem2", remaining, 2);
        @(negedge clk); chk("step3_rem1", remaining, 1);
        @(negedge clk);
        chk("step3_rem0", remaining, 0);
        chk("step3_en_off", core_en, 0);
        chk("step3_done", done, 1);
        chk("step3_cc", cycle_count, 3);
        @(negedge clk); chk("step3_done_off", done, 0);

        do_reset();
        cmd(2'b10, 0);
        repeat (9) @(negedge clk);
        chk("run_cc9", cycle_count, 9);
        chk("run_busy", busy, 1);
        cmd(2'b00, 0);
        chk("run_halt_cc", cycle_count, 11);
        chk("run_halt_done", done, 1);
        chk("run_halt_busy", busy, 0);
        chk("run_halt_en", core_en, 0);
        @(negedge clk);
        chk("run_halt_done_off", done, 0);
        chk("run_halt_cc_hold", cycle_count, 11);

        do_reset();
        cmd(2'b01, 0);
        chk("step0_done", done, 1);
        chk("step0_en", core_en, 0);
        cmd(2'b01, 5);
        chk("step5_rem", remaining, 5);
        cmd(2'b10, 0);
        chk("step5_err", cmd_err, 1);
        chk("step5_rem3", remaining, 3);
        repeat (2) @(negedge clk);
        chk("step5_rem1", remaining, 1);
        chk("step5_en", core_en, 1);
        @(negedge clk);
        chk("step5_en_off", core_en, 0);
        chk("step5_done", done, 1);
        chk("step5_cc", cycle_count, 5);
        chk("step5_err_sticky", cmd_err, 1);

        cmd(2'b01, 2);
        cmd(2'b00, 0);
        chk("last_halt_done", done, 1);
        chk("last_halt_en", core_en, 0);
        chk("last_halt_cc", cycle_count, 7);
        @(negedge clk);
        chk("last_halt_single", done, 0);

        do_reset();
        cmd(2'b10, 0);
        repeat (6) @(negedge clk);
        chk("rc_cc6", cycle_count, 6);
        cmd(2'b11, 0);
        chk("rc_en", core_en, 0);
        chk("rc_core_rst", core_rst, 1);
        chk("rc_cc", cycle_count, 0);
        chk("rc_done", done, 0);
        chk("rc_ready", cmd_ready, 0);
        repeat (4) begin
            @(negedge clk);
            chk("rc_hold_core_rst", core_rst, 1);
        end
        @(negedge clk);
        chk("rc_release", core_rst, 0);
        chk("rc_release_ready", cmd_ready, 1);

        cmd(2'b01, 10);
        cmd(2'b10, 0);
        chk("mid_err", cmd_err, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_core_en", core_en, 0);
        chk("async_core_rst", core_rst, 1);
        chk("async_remaining", remaining, 0);
        chk("async_cmd_err", cmd_err, 0);
        chk("async_done", done, 0);
        chk("async_busy", busy, 0);
        chk("async_cc", cycle_count, 0);
        chk("async_ready", cmd_ready, 0);
        do_reset();

        cmd(2'b10, 0);
        repeat (20) @(negedge clk);
        chk("sat_cc32", cycle_count, 20);
        chk("sat_cc4", s4_cc, 15);
        cmd(2'b00, 0);
        chk("sat_cc4_after", s4_cc, 15);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
